// File: rtl/count_display_driver.sv
// count_display_driver: shows the 4-bit counter value as two multiplexed 7-segment digits and counts wrap-around events.
module count_display_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LEAD = 1'b1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] CounterValue,
  input  logic       UpDown,
  input  logic       LoadCount,
  output logic [6:0] Segments,
  output logic [3:0] Anodes,
  output logic       WrapUp,
  output logic       WrapDown,
  output logic [7:0] WrapCount
);
  localparam int RW = $clog2(REFRESH_DIV);
  typedef enum logic {UNITS, TENS} digit_t;
  digit_t state, state_nxt;
  logic [RW-1:0] rcnt, rcnt_nxt;
  logic [3:0] count_q, units, an_nxt;
  logic ud_q, ld_q, tens, rwrap, wrap_up_nxt, wrap_dn_nxt;
  logic [6:0] units_seg, tens_seg, seg_nxt;
  logic [7:0] wc_nxt;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  always_comb begin
    tens = count_q >= 4'd10;
    units = tens ? count_q - 4'd10 : count_q;
    units_seg = seg7(units);
    tens_seg = tens ? seg7(4'd1) : (BLANK_LEAD ? 7'b1111111 : seg7(4'd0));
    rwrap = rcnt == RW'(REFRESH_DIV - 1);
    rcnt_nxt = rwrap ? '0 : rcnt + RW'(1);
    state_nxt = rwrap ? (state == UNITS ? TENS : UNITS) : state;
    seg_nxt = state == UNITS ? units_seg : tens_seg;
    an_nxt = state == UNITS ? 4'b1110 : 4'b1101;
    // a wrap is only genuine when the counter counted (no load) in the matching direction
    wrap_up_nxt = count_q == 4'd15 && CounterValue == 4'd0 && ud_q && !ld_q;
    wrap_dn_nxt = count_q == 4'd0 && CounterValue == 4'd15 && !ud_q && !ld_q;
    wc_nxt = (WrapUp || WrapDown) && WrapCount != 8'hff ? WrapCount + 8'd1 : WrapCount;
  end

  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      state <= UNITS;
      rcnt <= '0;
    end else begin
      state <= state_nxt;
      rcnt <= rcnt_nxt;
    end

  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      count_q <= 4'd0;
      ud_q <= 1'b0;
      ld_q <= 1'b0;
      Segments <= 7'b1111111;
      Anodes <= 4'b1111;
      WrapUp <= 1'b0;
      WrapDown <= 1'b0;
      WrapCount <= 8'd0;
    end else begin
      count_q <= CounterValue;
      ud_q <= UpDown;
      ld_q <= LoadCount;
      Segments <= seg_nxt;
      Anodes <= an_nxt;
      WrapUp <= wrap_up_nxt;
      WrapDown <= wrap_dn_nxt;
      WrapCount <= wc_nxt;
    end
endmodule

// File: tb/tb_count_display_driver.sv
// tb_count_display_driver: directed checks of display multiplexing, wrap strobes, wrap tally and async reset.
module tb_count_display_driver;
  logic Clock = 1'b0, Reset = 1'b1, UpDown = 1'b1, LoadCount = 1'b0;
  logic [3:0] CounterValue = 4'd0;
  logic [6:0] seg, seg0;
  logic [3:0] an, an0;
  logic wu, wd, wu0, wd0;
  logic [7:0] wc, wc0;
  int n_vec = 0, n_err = 0, cyc = 0;
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S3 = 7'b0110000, BL = 7'b1111111;

  always #5 Clock = ~Clock;

  count_display_driver #(.REFRESH_DIV(4), .BLANK_LEAD(1'b1)) dut (
    .Clock(Clock), .Reset(Reset), .CounterValue(CounterValue), .UpDown(UpDown), .LoadCount(LoadCount),
    .Segments(seg), .Anodes(an), .WrapUp(wu), .WrapDown(wd), .WrapCount(wc));

  count_display_driver #(.REFRESH_DIV(4), .BLANK_LEAD(1'b0)) dut0 (
    .Clock(Clock), .Reset(Reset), .CounterValue(CounterValue), .UpDown(UpDown), .LoadCount(LoadCount),
    .Segments(seg0), .Anodes(an0), .WrapUp(wu0), .WrapDown(wd0), .WrapCount(wc0));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    cyc++;
    @(negedge Clock);
  endtask

  function automatic bit units_slot();
    return ((cyc - 1) / 4) % 2 == 0;
  endfunction

  task automatic chk_disp(input string tag, input logic [6:0] u, input logic [6:0] t, input logic [6:0] t0);
    chk({tag, "_an"}, 8'(an), units_slot() ? 8'h0e : 8'h0d);
    chk({tag, "_an0"}, 8'(an0), units_slot() ? 8'h0e : 8'h0d);
    chk({tag, "_seg"}, 8'(seg), 8'(units_slot() ? u : t));
    chk({tag, "_seg0"}, 8'(seg0), 8'(units_slot() ? u : t0));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_an"}, 8'(an), 8'h0f);
    chk({tag, "_seg"}, 8'(seg), 8'h7f);
    chk({tag, "_wc"}, wc, 8'd0);
    chk({tag, "_wu"}, 8'(wu), 8'd0);
    chk({tag, "_wd"}, 8'(wd), 8'd0);
  endtask

  initial begin
    @(negedge Clock);
    chk_reset("rst0");
    Reset = 1'b0;
    cyc = 0;
    repeat (20) begin
      step();
      chk_disp("zero", S0, BL, S0);
    end
    CounterValue = 4'd13;
    step();
    step();
    repeat (8) begin
      chk_disp("thirteen", S3, S1, S1);
      step();
    end
    CounterValue = 4'd14; step();
    CounterValue = 4'd15; step();
    chk("up_pre", 8'(wu), 8'd0);
    CounterValue = 4'd0; step();
    chk("up_strobe", 8'(wu), 8'd1);
    chk("up_nodown", 8'(wd), 8'd0);
    chk("up_wc_lag", wc, 8'd0);
    CounterValue = 4'd1; step();
    chk("up_end", 8'(wu), 8'd0);
    chk("up_wc", wc, 8'd1);
    UpDown = 1'b0;
    CounterValue = 4'd0; step();
    chk("dn_pre", 8'(wd), 8'd0);
    CounterValue = 4'd15; step();
    chk("dn_strobe", 8'(wd), 8'd1);
    chk("dn_noup", 8'(wu), 8'd0);
    chk("dn_wc_lag", wc, 8'd1);
    CounterValue = 4'd14; step();
    chk("dn_end", 8'(wd), 8'd0);
    chk("dn_wc", wc, 8'd2);
    CounterValue = 4'd0; LoadCount = 1'b1; step();
    CounterValue = 4'd15; LoadCount = 1'b0; step();
    chk("ld_dn", 8'(wd), 8'd0);
    step();
    chk("ld_dn_wc", wc, 8'd2);
    UpDown = 1'b1; LoadCount = 1'b1; step();
    CounterValue = 4'd0; LoadCount = 1'b0; step();
    chk("ld_up", 8'(wu), 8'd0);
    step();
    chk("ld_up_wc", wc, 8'd2);
    CounterValue = 4'd15; step();
    CounterValue = 4'd0; UpDown = 1'b0; step();
    chk("b2b_up1", 8'(wu), 8'd1);
    chk("b2b_wc2", wc, 8'd2);
    CounterValue = 4'd15; UpDown = 1'b1; step();
    chk("b2b_dn", 8'(wd), 8'd1);
    chk("b2b_dn_noup", 8'(wu), 8'd0);
    chk("b2b_wc3", wc, 8'd3);
    CounterValue = 4'd0; UpDown = 1'b0; step();
    chk("b2b_up2", 8'(wu), 8'd1);
    chk("b2b_up2_nodn", 8'(wd), 8'd0);
    chk("b2b_wc4", wc, 8'd4);
    UpDown = 1'b1; step();
    chk("b2b_idle", 8'(wu | wd), 8'd0);
    chk("b2b_wc5", wc, 8'd5);
    repeat (256) begin
      CounterValue = 4'd15; step();
      CounterValue = 4'd0; step();
      chk("sat_up", 8'(wu), 8'd1);
    end
    step();
    chk("sat_wc", wc, 8'hff);
    repeat (3) begin
      CounterValue = 4'd15; step();
      CounterValue = 4'd0; step();
    end
    step();
    chk("sat_hold", wc, 8'hff);
    #2 Reset = 1'b1;
    #1 chk_reset("rst1");
    @(negedge Clock);
    Reset = 1'b0;
    cyc = 0;
    CounterValue = 4'd0;
    UpDown = 1'b1;
    step();
    repeat (5) begin
      CounterValue = 4'd15; step();
      CounterValue = 4'd0; step();
    end
    step();
    chk("five_wc", wc, 8'd5);
    repeat (2) step();
    chk("mid_tens_an", 8'(an), 8'h0d);
    #2 Reset = 1'b1;
    #1 chk_reset("rst2");
    chk("rst2_an0", 8'(an0), 8'h0f);
    @(negedge Clock);
    Reset = 1'b0;
    cyc = 0;
    step();
    chk("post_rst_units", 8'(an), 8'h0e);
    chk("post_rst_seg", 8'(seg), 8'(S0));
    chk("post_rst_wc", wc, 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
